// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter shared types: FSM state encoding and master IDs.
// Imported by the arbiter top and its winner-select sub-module.
package cache_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// SRAM-like bus bundle: request fields out of a master, response back.
// master drives the request, slave drives the response.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              addr_ok;
    logic              data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/cache_mem_arbiter_pick.sv
// Winner select between I- and D-cache requests.
// CACHE_ARB_RR_EN: on a tie grant the master not served last.
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last,
    output logic gnt
);

`ifdef CACHE_ARB_RR_EN
    // tie goes to whoever was not served last
    always_comb begin
        if (i_req && d_req) begin
            gnt = ~last;
        end else begin
            gnt = d_req ? GNT_D : GNT_I;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    // fixed priority, D-cache beats I-cache
    always_comb begin
        gnt = d_req ? GNT_D : GNT_I;
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one SRAM-like memory port between I- and D-cache, one txn at a time.
// Define CACHE_ARB_RR_EN for round-robin on ties (default: D over I).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic resetn,
    cache_mem_arbiter_if.slave  i_bus,
    cache_mem_arbiter_if.slave  d_bus,
    cache_mem_arbiter_if.master m_bus
);

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last;
    logic   pick_gnt;

    logic in_idle, in_addr, in_data;
    logic g_req, addr_hs, data_hs;

    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef CACHE_ARB_RR_EN
    logic last_q;

    // remember who finished the most recent transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= GNT_I;
        end else if (data_hs) begin
            last_q <= gnt_q;
        end
    end

    assign last = last_q;
`else
    assign last = GNT_I;
`endif

    cache_arb_pick u_pick (
        .i_req (i_bus.req),
        .d_req (d_bus.req),
        .last  (last),
        .gnt   (pick_gnt)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign in_addr = (state_q == ST_ADDR);
    assign in_data = (state_q == ST_DATA);

    assign g_req   = (gnt_q == GNT_D) ? d_bus.req : i_bus.req;
    assign addr_hs = in_addr & g_req & m_bus.addr_ok;
    assign data_hs = in_data & m_bus.data_ok;

    assign sel_wr    = (gnt_q == GNT_D) ? d_bus.wr    : i_bus.wr;
    assign sel_size  = (gnt_q == GNT_D) ? d_bus.size  : i_bus.size;
    assign sel_addr  = (gnt_q == GNT_D) ? d_bus.addr  : i_bus.addr;
    assign sel_wdata = (gnt_q == GNT_D) ? d_bus.wdata : i_bus.wdata;

    assign m_bus.req   = in_addr & g_req;
    assign m_bus.wr    = sel_wr;
    assign m_bus.size  = sel_size;
    assign m_bus.addr  = sel_addr;
    assign m_bus.wdata = sel_wdata;

    assign i_bus.addr_ok = addr_hs & (gnt_q == GNT_I);
    assign d_bus.addr_ok = addr_hs & (gnt_q == GNT_D);
    assign i_bus.data_ok = data_hs & (gnt_q == GNT_I);
    assign d_bus.data_ok = data_hs & (gnt_q == GNT_D);
    assign i_bus.rdata   = m_bus.rdata;
    assign d_bus.rdata   = m_bus.rdata;

    // next state and grant; grant only moves when leaving IDLE
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        unique case (1'b1)
            in_idle: begin
                if (i_bus.req || d_bus.req) begin
                    gnt_d   = pick_gnt;
                    state_d = ST_ADDR;
                end
            end
            in_addr: begin
                if (!g_req) begin
                    state_d = ST_IDLE;
                end else if (m_bus.addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            in_data: begin
                if (m_bus.data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and grant registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_I;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of masters, memory and arbitration.
module tb_cache_mem_arbiter;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();
    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) db ();
    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb ();

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .i_bus  (ib),
        .d_bus  (db),
        .m_bus  (mb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        ib.req = 0; ib.wr = 0; ib.size = 2'd2; ib.addr = 0; ib.wdata = 0;
        db.req = 0; db.wr = 0; db.size = 2'd2; db.addr = 0; db.wdata = 0;
        mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = 0;
    endtask

    task automatic oks_zero(string tag);
        chk({tag, "_iaok"}, ib.addr_ok, 0);
        chk({tag, "_daok"}, db.addr_ok, 0);
        chk({tag, "_idok"}, ib.data_ok, 0);
        chk({tag, "_ddok"}, db.data_ok, 0);
    endtask

    task automatic do_reset();
        clr_inputs();
        resetn = 0;
        nxt();
        ib.req = 1;
        db.req = 1;
        mb.addr_ok = 1;
        mb.data_ok = 1;
        #1;
        chk("rst_mreq", mb.req, 0);
        oks_zero("rst");
        nxt();
        clr_inputs();
        resetn = 1;
    endtask

    // random-phase model state
    logic        rq [2];
    logic        wr [2];
    logic        busy [2];
    logic [1:0]  sz [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] mem [64];
    logic        win;
    logic        last_srv;
    int          phase;
    int          dly;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_wr;
    logic        e_mreq;
    logic        e_aok [2];
    logic        e_dok [2];
    logic        do_aok;
    logic        was_tie;
    logic [31:0] exp_rd;

    function automatic logic tie_winner(logic last_served);
`ifdef CACHE_ARB_RR_EN
        return ~last_served;
`else
        return last_served | 1'b1;
`endif
    endfunction

    initial begin
        total = 0;
        bad = 0;
        resetn = 1;
        clr_inputs();

        // lone I-cache read, memory slow on both phases
        do_reset();
        ib.req = 1; ib.addr = 32'h0000_1000;
        #1 chk("t1_c0_mreq", mb.req, 0);
        nxt();
        #1 chk("t1_c1_mreq", mb.req, 1);
        chk("t1_c1_maddr", mb.addr, 32'h0000_1000);
        chk("t1_c1_iaok", ib.addr_ok, 0);
        nxt();
        mb.addr_ok = 1;
        #1 chk("t1_c2_iaok", ib.addr_ok, 1);
        chk("t1_c2_daok", db.addr_ok, 0);
        nxt();
        mb.addr_ok = 0; ib.req = 0;
        #1 chk("t1_c3_mreq", mb.req, 0);
        chk("t1_c3_idok", ib.data_ok, 0);
        nxt();
        mb.data_ok = 1; mb.rdata = 32'hDEAD_BEEF;
        #1 chk("t1_c4_idok", ib.data_ok, 1);
        chk("t1_c4_irdata", ib.rdata, 32'hDEAD_BEEF);
        chk("t1_c4_ddok", db.data_ok, 0);
        nxt();
        mb.data_ok = 0;

        // both masters requesting continuously for four rounds
        do_reset();
        ib.req = 1; ib.addr = 32'h0000_1100;
        db.req = 1; db.addr = 32'h0000_2200;
        for (int r = 0; r < 4; r++) begin
            logic ew;
`ifdef CACHE_ARB_RR_EN
            ew = (r % 2 == 0);
`else
            ew = 1'b1;
`endif
            #1 chk($sformatf("t2_r%0d_bubble", r), mb.req, 0);
            nxt();
            mb.addr_ok = 1;
            #1 chk($sformatf("t2_r%0d_mreq", r), mb.req, 1);
            chk($sformatf("t2_r%0d_maddr", r), mb.addr,
                ew ? 32'h0000_2200 : 32'h0000_1100);
            chk($sformatf("t2_r%0d_iaok", r), ib.addr_ok, {31'd0, ~ew});
            chk($sformatf("t2_r%0d_daok", r), db.addr_ok, {31'd0, ew});
            nxt();
            mb.addr_ok = 0; mb.data_ok = 1;
            #1 chk($sformatf("t2_r%0d_idok", r), ib.data_ok, {31'd0, ~ew});
            chk($sformatf("t2_r%0d_ddok", r), db.data_ok, {31'd0, ew});
            nxt();
            mb.data_ok = 0;
        end
        clr_inputs();

        // D-cache write fields routed while in ADDR
        do_reset();
        db.req = 1; db.wr = 1;
        db.addr = 32'h0000_2004; db.wdata = 32'h1234_5678;
        nxt();
        #1 chk("t3_c1_mreq", mb.req, 1);
        chk("t3_c1_mwr", mb.wr, 1);
        chk("t3_c1_maddr", mb.addr, 32'h0000_2004);
        chk("t3_c1_mwdata", mb.wdata, 32'h1234_5678);
        nxt();
        mb.addr_ok = 1;
        #1 chk("t3_c2_mwr", mb.wr, 1);
        chk("t3_c2_mwdata", mb.wdata, 32'h1234_5678);
        chk("t3_c2_daok", db.addr_ok, 1);
        nxt();
        mb.addr_ok = 0; db.req = 0; db.wr = 0; mb.data_ok = 1;
        #1 chk("t3_c3_ddok", db.data_ok, 1);
        nxt();
        mb.data_ok = 0;

        // D-cache aborts in ADDR before the handshake
        do_reset();
        db.req = 1; db.addr = 32'h0000_2008;
        nxt();
        #1 chk("t4_c1_mreq", mb.req, 1);
        nxt();
        db.req = 0; mb.addr_ok = 1;
        #1 chk("t4_c2_mreq", mb.req, 0);
        chk("t4_c2_daok", db.addr_ok, 0);
        nxt();
        mb.addr_ok = 0; mb.data_ok = 1;
        #1 chk("t4_c3_mreq", mb.req, 0);
        chk("t4_c3_ddok", db.data_ok, 0);
        nxt();
        mb.data_ok = 0; ib.req = 1; ib.addr = 32'h0000_100C;
        #1 chk("t4_c4_mreq", mb.req, 0);
        nxt();
        mb.addr_ok = 1;
        #1 chk("t4_c5_maddr", mb.addr, 32'h0000_100C);
        chk("t4_c5_iaok", ib.addr_ok, 1);
        nxt();
        mb.addr_ok = 0; ib.req = 0; mb.data_ok = 1;
        #1 chk("t4_c6_idok", ib.data_ok, 1);
        nxt();
        mb.data_ok = 0;

        // reset pulse while waiting for data
        do_reset();
        ib.req = 1; ib.addr = 32'h0000_1300;
        nxt();
        mb.addr_ok = 1;
        #1 chk("t5_iaok", ib.addr_ok, 1);
        nxt();
        mb.addr_ok = 0; ib.req = 0;
        #2;
        resetn = 0; mb.data_ok = 1;
        #1 chk("t5_rst_mreq", mb.req, 0);
        oks_zero("t5_rst");
        nxt();
        resetn = 1;
        #1 chk("t5_after_idok", ib.data_ok, 0);
        chk("t5_after_ddok", db.data_ok, 0);
        nxt();
        mb.data_ok = 0; ib.req = 1; ib.addr = 32'h0000_1304;
        nxt();
        mb.addr_ok = 1;
        #1 chk("t5_new_maddr", mb.addr, 32'h0000_1304);
        chk("t5_new_iaok", ib.addr_ok, 1);
        nxt();
        mb.addr_ok = 0; ib.req = 0;
        mb.data_ok = 1; mb.rdata = 32'hCAFE_F00D;
        #1 chk("t5_new_idok", ib.data_ok, 1);
        chk("t5_new_irdata", ib.rdata, 32'hCAFE_F00D);
        nxt();
        mb.data_ok = 0;

        // random traffic against transaction-level model
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        for (int m = 0; m < 2; m++) begin
            rq[m] = 0; wr[m] = 0; busy[m] = 0;
            sz[m] = 0; ad[m] = 0; wd[m] = 0;
        end
        do_reset();
        last_srv = 1'b0;
        phase = 0;
        dly = 0;
        win = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq[m] && !busy[m] && $urandom_range(2) == 0) begin
                    rq[m] = 1;
                    wr[m] = 1'($urandom_range(1));
                    sz[m] = 2'($urandom_range(3));
                    ad[m] = (m == 1 ? 32'h0000_2000 : 32'h0000_1000)
                          | (32'($urandom_range(63)) << 2);
                    wd[m] = $urandom;
                end
            end
            ib.req = rq[0]; ib.wr = wr[0]; ib.size = sz[0];
            ib.addr = ad[0]; ib.wdata = wd[0];
            db.req = rq[1]; db.wr = wr[1]; db.size = sz[1];
            db.addr = ad[1]; db.wdata = wd[1];
            mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = $urandom;
            e_mreq = 0;
            e_aok[0] = 0; e_aok[1] = 0;
            e_dok[0] = 0; e_dok[1] = 0;
            do_aok = 0;
            was_tie = 0;
            case (phase)
                0: begin
                    mb.addr_ok = ($urandom_range(3) == 0);
                    mb.data_ok = ($urandom_range(3) == 0);
                end
                1: begin
                    e_mreq = 1;
                    do_aok = 1'($urandom_range(1));
                    mb.addr_ok = do_aok;
                    mb.data_ok = ($urandom_range(3) == 0);
                    e_aok[win] = do_aok;
                end
                default: begin
                    if (dly == 0) begin
                        mb.data_ok = 1;
                        if (!lat_wr) mb.rdata = mem[lat_addr[7:2]];
                        e_dok[win] = 1;
                    end else begin
                        mb.addr_ok = ($urandom_range(2) == 0);
                    end
                end
            endcase
            #1;
            chk("rnd_mreq", mb.req, {31'd0, e_mreq});
            if (e_mreq) begin
                chk("rnd_maddr", mb.addr, ad[win]);
                chk("rnd_mwr", mb.wr, {31'd0, wr[win]});
                chk("rnd_msize", mb.size, {30'd0, sz[win]});
                if (wr[win]) chk("rnd_mwdata", mb.wdata, wd[win]);
            end
            chk("rnd_iaok", ib.addr_ok, {31'd0, e_aok[0]});
            chk("rnd_daok", db.addr_ok, {31'd0, e_aok[1]});
            chk("rnd_idok", ib.data_ok, {31'd0, e_dok[0]});
            chk("rnd_ddok", db.data_ok, {31'd0, e_dok[1]});
            if (phase == 2 && dly == 0 && !wr[win]) begin
                exp_rd = mem[ad[win][7:2]];
                chk("rnd_rdata", win ? db.rdata : ib.rdata, exp_rd);
            end
            case (phase)
                0: begin
                    if (rq[0] || rq[1]) begin
                        was_tie = rq[0] && rq[1];
                        win = was_tie ? tie_winner(last_srv) : rq[1];
                        phase = 1;
                    end
                end
                1: begin
                    if (do_aok) begin
                        lat_addr = mb.addr;
                        lat_wr = mb.wr;
                        lat_wdata = mb.wdata;
                        busy[win] = 1;
                        rq[win] = 0;
                        dly = $urandom_range(3);
                        phase = 2;
                    end
                end
                default: begin
                    if (dly == 0) begin
                        if (lat_wr) mem[lat_addr[7:2]] = lat_wdata;
                        busy[win] = 0;
                        last_srv = win;
                        phase = 0;
                    end else begin
                        dly--;
                    end
                end
            endcase
            nxt();
        end
        clr_inputs();
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
